// File: rtl/sig_gen.sv
// sig_gen: programmable square-wave source for the frequency-counter path.
// A requested frequency is turned into a half-period (in clk cycles) by an
// iterative restoring divider, then sigout toggles every half-period.
//
// Ports:
//   clk      in   1       system clock, rising edge
//   reset    in   1       asynchronous, active-low reset
//   freq_in  in   FREQ_W  requested frequency in Hz (unsigned)
//   load     in   1       one-cycle strobe, samples freq_in when not busy
//   sigout   out  1       generated square wave, 50% duty
//   busy     out  1       divide in progress; load ignored while high
//   active   out  1       sigout is toggling
//   err      out  1       last request rejected (0, above FREQ_MAX, or hp==0)
module sig_gen #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned FREQ_W   = 16,
    parameter int unsigned FREQ_MAX = 9999,
    parameter int unsigned DIV_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              load,
    output logic              sigout,
    output logic              busy,
    output logic              active,
    output logic              err
);

    localparam int unsigned       IT_W       = $clog2(DIV_W);
    localparam logic [FREQ_W-1:0] FREQ_MAX_V = FREQ_W'(FREQ_MAX);
    localparam logic [DIV_W-1:0]  DIVIDEND   = DIV_W'(CLK_HZ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_RUN    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic [IT_W-1:0]   it_q, it_d;
    logic [DIV_W-1:0]  quo_q, quo_d;
    logic [DIV_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]  divisor_q, divisor_d;
    logic [DIV_W-1:0]  half_q, half_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [DIV_W-1:0]  pend_hp_q, pend_hp_d;
    logic              sigout_q, sigout_d;
    logic              active_q, active_d;
    logic              err_q, err_d;

    // Divider step: shift the next dividend bit into the remainder, subtract if it fits.
    logic [DIV_W:0]    rem_sh;
    logic [DIV_W-1:0]  rem_sub;
    logic              q_bit;
    logic [DIV_W-1:0]  rem_nx;
    logic [DIV_W-1:0]  quo_nx;
    logic              div_done;
    logic              toggle;
    logic              freq_bad;
    logic [FREQ_W:0]   freq_dbl;

    always_comb begin
        rem_sh   = {rem_q, quo_q[DIV_W-1]};
        q_bit    = (rem_sh >= {1'b0, divisor_q});
        rem_sub  = DIV_W'(rem_sh - {1'b0, divisor_q});
        rem_nx   = q_bit ? rem_sub : rem_sh[DIV_W-1:0];
        quo_nx   = {quo_q[DIV_W-2:0], q_bit};
        div_done = busy_q && (it_q == IT_W'(DIV_W - 1));
        toggle   = (state_q == S_RUN) && (cnt_q == (half_q - DIV_W'(1)));
        freq_bad = (freq_in == '0) || (freq_in > FREQ_MAX_V);
        freq_dbl = {freq_in, 1'b0};
    end

    // Next-state logic; later blocks take priority over earlier ones.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        it_d      = it_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_hp_d = pend_hp_q;
        sigout_d  = sigout_q;
        active_d  = active_q;
        err_d     = err_q;

        if (busy_q) begin
            it_d  = it_q + IT_W'(1);
            rem_d = rem_nx;
            quo_d = quo_nx;
        end

        // Half-period counter; a pending retune takes effect exactly at a toggle.
        if (state_q == S_RUN) begin
            if (toggle) begin
                cnt_d    = '0;
                sigout_d = ~sigout_q;
                if (pend_q) begin
                    half_d = pend_hp_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // quo_nx is the final quotient on the last divider iteration.
        if (div_done) begin
            busy_d = 1'b0;
            it_d   = '0;
            if (quo_nx == '0) begin
                err_d    = 1'b1;
                state_d  = S_IDLE;
                active_d = 1'b0;
                sigout_d = 1'b0;
                cnt_d    = '0;
                pend_d   = 1'b0;
            end else if (state_q == S_RUN) begin
                if (toggle) begin
                    half_d = quo_nx;
                    pend_d = 1'b0;
                end else begin
                    pend_d    = 1'b1;
                    pend_hp_d = quo_nx;
                end
            end else begin
                state_d  = S_RUN;
                half_d   = quo_nx;
                cnt_d    = '0;
                sigout_d = 1'b0;
                active_d = 1'b1;
            end
        end

        // New request; busy_q blocks it, including the cycle the divide completes.
        if (load && !busy_q) begin
            if (freq_bad) begin
                err_d    = 1'b1;
                state_d  = S_IDLE;
                sigout_d = 1'b0;
                active_d = 1'b0;
                cnt_d    = '0;
                pend_d   = 1'b0;
            end else begin
                err_d     = 1'b0;
                busy_d    = 1'b1;
                it_d      = '0;
                rem_d     = '0;
                quo_d     = DIVIDEND;
                divisor_d = DIV_W'(freq_dbl);
                if (state_q != S_RUN) begin
                    state_d = S_DIVIDE;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            it_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            half_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_hp_q <= '0;
            sigout_q  <= 1'b0;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            it_q      <= it_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            half_q    <= half_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_hp_q <= pend_hp_d;
            sigout_q  <= sigout_d;
            active_q  <= active_d;
            err_q     <= err_d;
        end
    end

    assign sigout = sigout_q;
    assign busy   = busy_q;
    assign active = active_q;
    assign err    = err_q;

endmodule
